// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA raster timing generator (640x480@60 Hz at defaults).
//                Every output is registered from the same next raster position.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               w_adv;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;

    // Next raster position; only consumed on an advance edge.
    always_comb begin
        w_adv    = (r_div == c_DIV_LAST);
        w_h_next = hcount + 10'd1;
        w_v_next = vcount;
        if (hcount == c_H_LAST) begin
            w_h_next = 10'd0;
            w_v_next = (vcount == c_V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            hcount     <= c_H_LAST;
            vcount     <= c_V_LAST;
            video_on   <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            pix_tick   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pix_tick   <= w_adv;
            frame_tick <= w_adv && (w_h_next == 10'd0) && (w_v_next == c_V_ACT);
            if (w_adv) begin
                r_div    <= '0;
                hcount   <= w_h_next;
                vcount   <= w_v_next;
                video_on <= (w_h_next < c_H_ACT) && (w_v_next < c_V_ACT);
                hsync    <= !((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST));
                vsync    <= !((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST));
            end else begin
                r_div    <= r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Scoreboard bench for vga_sync_gen: default timing plus two
//                scaled rasters (CLK_DIV=1 and CLK_DIV=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       von;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] hc0, vc0, hc1, vc1, hc2, vc2;
    logic pt0, von0, hs0, vs0, ft0;
    logic pt1, von1, hs1, vs1, ft1;
    logic pt2, von2, hs2, vs2, ft2;

    vga_sync_gen u_dut0 (
        .clk(clk), .rst(rst), .pix_tick(pt0), .hcount(hc0), .vcount(vc0),
        .video_on(von0), .hsync(hs0), .vsync(vs0), .frame_tick(ft0)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .pix_tick(pt1), .hcount(hc1), .vcount(vc1),
        .video_on(von1), .hsync(hs1), .vsync(vs1), .frame_tick(ft1)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .pix_tick(pt2), .hcount(hc2), .vcount(vc2),
        .video_on(von2), .hsync(hs2), .vsync(vs2), .frame_tick(ft2)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   k = 0;
    bit   cnt_en = 1'b0;
    int   hs_low = 0;
    int   last1 = -1, last2 = -1, nft1 = 0, nft2 = 0;

    // Reference: k = edges since reset released; pixel n is shown from edge div*(n+1).
    function automatic exp_t model(input int kk, input int div,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        exp_t e;
        int ht, vt, m, n, pos, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (kk < div) begin
            e = '{hc: 10'(ht - 1), vc: 10'(vt - 1), von: 1'b0, hs: 1'b1, vs: 1'b1,
                  pt: 1'b0, ft: 1'b0};
        end else begin
            m     = kk - div;
            n     = m / div;
            pos   = n % (ht * vt);
            h     = pos % ht;
            v     = pos / ht;
            e.hc  = 10'(h);
            e.vc  = 10'(v);
            e.von = (h < ha) && (v < va);
            e.hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
            e.vs  = !((v >= va + vf) && (v < va + vf + vsw));
            e.pt  = (m % div) == 0;
            e.ft  = e.pt && (h == 0) && (v == va);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @k=%0d: got h=%0d v=%0d von=%b hs=%b vs=%b pt=%b ft=%b, expected h=%0d v=%0d von=%b hs=%b vs=%b pt=%b ft=%b",
                     name, k, act.hc, act.vc, act.von, act.hs, act.vs, act.pt, act.ft,
                     exp.hc, exp.vc, exp.von, exp.hs, exp.vs, exp.pt, exp.ft);
        end
    endtask

    // Monitor: outputs present a new raster state every clk; pop and compare.
    always @(negedge clk) begin
        if (q0.size() > 0) cmp("dut0", exp_t'({hc0, vc0, von0, hs0, vs0, pt0, ft0}), q0.pop_front());
        if (q1.size() > 0) cmp("dut1", exp_t'({hc1, vc1, von1, hs1, vs1, pt1, ft1}), q1.pop_front());
        if (q2.size() > 0) cmp("dut2", exp_t'({hc2, vc2, von2, hs2, vs2, pt2, ft2}), q2.pop_front());
    end

    task automatic step(input bit r);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        k = r ? 0 : k + 1;
        q0.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q1.push_back(model(k, 1, 8, 2, 2, 2, 4, 1, 1, 1));
        q2.push_back(model(k, 3, 8, 2, 2, 2, 4, 1, 1, 1));
        #1;
        if (cnt_en) begin
            if (vc0 == 10'd0 && !hs0) hs_low++;
            if (ft1) begin
                if (last1 >= 0) chk("ft1_interval", k - last1, 98);
                else            chk("ft1_first", k, 57);
                last1 = k;
                nft1++;
            end
            if (ft2) begin
                if (last2 >= 0) chk("ft2_interval", k - last2, 294);
                else            chk("ft2_first", k, 171);
                last2 = k;
                nft2++;
            end
        end
    endtask

    task automatic restart_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk({tag, "_hold_hcount"}, hc0, 799);
            chk({tag, "_hold_pix_tick"}, pt0, 0);
        end
        step(1'b0);
        chk({tag, "_first_hcount"}, hc0, 0);
        chk({tag, "_first_vcount"}, vc0, 0);
        chk({tag, "_first_video_on"}, von0, 1);
        chk({tag, "_first_pix_tick"}, pt0, 1);
        step(1'b0);
        chk({tag, "_second_pix_tick"}, pt0, 0);
        chk({tag, "_second_hcount"}, hc0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) step(1'b1);
        chk("rst_hcount", hc0, 799);
        chk("rst_vcount", vc0, 524);
        chk("rst_hsync", hs0, 1);
        chk("rst_video_on", von0, 0);
        restart_check("release");

        // Two full lines of default timing plus dense scaled frames.
        cnt_en = 1'b1;
        while (k < 6600) step(1'b0);
        cnt_en = 1'b0;
        chk("hsync_low_clk_line0", hs_low, 384);
        chk("vcount_after_2lines", vc0, 2);
        chk("dut1_frame_count", nft1, 67);
        chk("dut2_frame_count", nft2, 22);

        // Mid-line reset at hcount=300, vcount=2, divider phase 2.
        while (k < 7606) step(1'b0);
        chk("pre_rst_hcount", hc0, 300);
        step(1'b1);
        chk("midrst_hcount", hc0, 799);
        chk("midrst_vcount", vc0, 524);
        chk("midrst_pix_tick", pt0, 0);
        restart_check("restart");

        // Three scaled frames at CLK_DIV=3 after the restart.
        last1 = -1; last2 = -1; nft1 = 0; nft2 = 0;
        cnt_en = 1'b1;
        while (k < 905) step(1'b0);
        cnt_en = 1'b0;
        chk("dut2_3frames", nft2, 3);
        chk("dut1_frames", nft1, 9);

        repeat (5) step(1'b1);
        chk("rst_frame_tick", ft1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
